// File: rtl/gps_nmea_pkg.sv
// Shared types and constants for the NMEA sentence framer: FSM states,
// ASCII markers, register map and the checksum-digit decoder.
package gps_nmea_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BODY,
        CS_HI,
        CS_LO,
        CR,
        LF
    } nmeaState_t;

    localparam logic [7:0] ASCII_DOLLAR = 8'h24;
    localparam logic [7:0] ASCII_STAR   = 8'h2A;
    localparam logic [7:0] ASCII_CR     = 8'h0D;
    localparam logic [7:0] ASCII_LF     = 8'h0A;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_ERRORS = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int STATUS_BUSY_BIT  = 16;
    localparam int STATUS_IRQEN_BIT = 17;
    localparam int ERR_CSUM_LSB     = 0;
    localparam int ERR_FMT_LSB      = 8;
    localparam int ERR_OVF_LSB      = 16;

    typedef struct packed {
        logic       valid;
        logic [3:0] nibble;
    } hexNibble_t;

    // Only uppercase hex digits are legal in an NMEA checksum field.
    function automatic hexNibble_t hex_to_nibble(input logic [7:0] c);
        hexNibble_t r;
        r = '{valid: 1'b0, nibble: 4'h0};
        if (c >= 8'h30 && c <= 8'h39) begin
            r.valid  = 1'b1;
            r.nibble = c[3:0];
        end else if (c >= 8'h41 && c <= 8'h46) begin
            r.valid  = 1'b1;
            r.nibble = c[3:0] + 4'd9;
        end
        return r;
    endfunction

endpackage

// File: rtl/nmea_byte_ram.sv
// Simple dual-port byte store for the sentence FIFO; registered read so it
// maps onto a block RAM and supplies the one-cycle DATA read latency.
module nmea_byte_ram #(
    parameter int DEPTH = 256
) (
    input  logic                     i_clk,
    input  logic                     i_wrEn,
    input  logic [$clog2(DEPTH)-1:0] i_wrAddr,
    input  logic [7:0]               i_wrData,
    input  logic [$clog2(DEPTH)-1:0] i_rdAddr,
    output logic [7:0]               o_rdData
);

    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
        o_rdData <= r_mem[i_rdAddr];
    end

endmodule

// File: rtl/gps_nmea_framer.sv
// Frames NMEA-0183 sentences from the GPS UART byte stream, verifies their
// XOR checksum and exposes only complete, valid sentences over Avalon-MM.
module gps_nmea_framer
    import gps_nmea_pkg::*;
#(
    parameter int FIFO_DEPTH = 256,
    parameter int MAX_LEN    = 82
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    input  logic [1:0]  i_avs_address,
    input  logic        i_avs_read,
    output logic [31:0] o_avs_readdata,
    input  logic        i_avs_write,
    input  logic [31:0] i_avs_writedata,
    output logic        o_irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int LW = $clog2(MAX_LEN + 1);

    nmeaState_t r_state, w_nextState, w_tryState;
    logic [PW-1:0] r_wrPtr, r_cmPtr, r_rdPtr, w_base, w_used, w_avail;
    logic [LW-1:0] r_len;
    logic [7:0]    r_csum, r_rxCsum, r_csumErr, r_fmtErr, r_ovfErr, w_ramQ;
    logic [31:0]   r_regData, w_status;
    logic          r_irqEn, r_irq, r_dataPop;
    logic          w_isDollar, w_isStar, w_try, w_start, w_badChar, w_wrEn, w_abort;
    logic          w_commit, w_fmtErr, w_csumErr, w_ovfErr, w_pop, w_unusedBits;
    hexNibble_t    w_hex;

    assign w_avail      = r_cmPtr - r_rdPtr;
    assign w_pop        = i_avs_read && (i_avs_address == REG_DATA) && (w_avail != '0);
    assign w_unusedBits = ^i_avs_writedata[31:1];

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= IDLE;
        else         r_state <= w_nextState;
    end

    // A '$' always (re)starts a sentence at the committed pointer; every other
    // stored byte goes at wr_ptr, subject to the length and space limits.
    always_comb begin
        w_hex       = hex_to_nibble(i_rx_data);
        w_isDollar  = (i_rx_data == ASCII_DOLLAR);
        w_isStar    = (i_rx_data == ASCII_STAR);
        w_try       = 1'b0;
        w_start     = 1'b0;
        w_badChar   = 1'b0;
        w_tryState  = r_state;
        w_nextState = r_state;
        w_wrEn      = 1'b0;
        w_abort     = 1'b0;
        w_commit    = 1'b0;
        w_fmtErr    = 1'b0;
        w_csumErr   = 1'b0;
        w_ovfErr    = 1'b0;
        if (i_rx_valid) begin
            if (w_isDollar) begin
                w_try      = 1'b1;
                w_start    = 1'b1;
                w_tryState = BODY;
                w_fmtErr   = (r_state != IDLE);
            end else begin
                case (r_state)
                    BODY:    begin w_try = 1'b1; w_tryState = w_isStar ? CS_HI : BODY; end
                    CS_HI:   begin w_try = w_hex.valid; w_badChar = !w_hex.valid; w_tryState = CS_LO; end
                    CS_LO:   begin w_try = w_hex.valid; w_badChar = !w_hex.valid; w_tryState = CR; end
                    CR:      begin w_try = (i_rx_data == ASCII_CR); w_badChar = !w_try; w_tryState = LF; end
                    LF:      begin w_try = (i_rx_data == ASCII_LF); w_badChar = !w_try; w_tryState = IDLE; end
                    default: w_try = 1'b0;
                endcase
            end
        end
        w_base = w_start ? r_cmPtr : r_wrPtr;
        w_used = w_base - r_rdPtr;
        if (w_badChar) begin
            w_fmtErr    = 1'b1;
            w_abort     = 1'b1;
            w_nextState = IDLE;
        end else if (w_try) begin
            if (!w_start && r_len >= LW'(MAX_LEN)) begin
                w_fmtErr    = 1'b1;
                w_abort     = 1'b1;
                w_nextState = IDLE;
            end else if (w_used == PW'(FIFO_DEPTH)) begin
                w_ovfErr    = 1'b1;
                w_abort     = 1'b1;
                w_nextState = IDLE;
            end else begin
                w_wrEn      = 1'b1;
                w_nextState = w_tryState;
                if (r_state == LF && !w_start) begin
                    w_commit  = (r_rxCsum == r_csum);
                    w_csumErr = !w_commit;
                    w_abort   = !w_commit;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wrPtr  <= '0;
            r_cmPtr  <= '0;
            r_rdPtr  <= '0;
            r_len    <= '0;
            r_csum   <= '0;
            r_rxCsum <= '0;
        end else begin
            if (w_abort)     r_wrPtr <= r_cmPtr;
            else if (w_wrEn) r_wrPtr <= w_base + PW'(1);
            if (w_commit)    r_cmPtr <= r_wrPtr + PW'(1);
            if (w_pop)       r_rdPtr <= r_rdPtr + PW'(1);
            if (w_wrEn) begin
                if (w_start) begin
                    r_csum <= '0;
                    r_len  <= LW'(1);
                end else begin
                    r_len <= r_len + LW'(1);
                    if (r_state == BODY && !w_isStar) r_csum <= r_csum ^ i_rx_data;
                    if (r_state == CS_HI) r_rxCsum[7:4] <= w_hex.nibble;
                    if (r_state == CS_LO) r_rxCsum[3:0] <= w_hex.nibble;
                end
            end
        end
    end

    // Error counters saturate; a write to ERRORS wins over a same-cycle increment.
    always_ff @(posedge i_clk) begin
        if (i_reset || (i_avs_write && i_avs_address == REG_ERRORS)) begin
            r_csumErr <= '0;
            r_fmtErr  <= '0;
            r_ovfErr  <= '0;
        end else begin
            if (w_csumErr && r_csumErr != 8'hFF) r_csumErr <= r_csumErr + 8'd1;
            if (w_fmtErr  && r_fmtErr  != 8'hFF) r_fmtErr  <= r_fmtErr  + 8'd1;
            if (w_ovfErr  && r_ovfErr  != 8'hFF) r_ovfErr  <= r_ovfErr  + 8'd1;
        end
    end

    always_comb begin
        w_status                   = '0;
        w_status[15:0]             = 16'(w_avail);
        w_status[STATUS_BUSY_BIT]  = (r_state != IDLE);
        w_status[STATUS_IRQEN_BIT] = r_irqEn;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_irqEn   <= 1'b0;
            r_irq     <= 1'b0;
            r_dataPop <= 1'b0;
            r_regData <= '0;
        end else begin
            if (i_avs_write && i_avs_address == REG_CTRL) r_irqEn <= i_avs_writedata[0];
            r_irq     <= r_irqEn && (w_avail != '0);
            r_dataPop <= w_pop;
            r_regData <= '0;
            if (i_avs_read) begin
                case (i_avs_address)
                    REG_STATUS: r_regData <= w_status;
                    REG_ERRORS: r_regData <= {8'd0, r_ovfErr, r_fmtErr, r_csumErr};
                    REG_CTRL:   r_regData <= {31'd0, r_irqEn};
                    default:    r_regData <= '0;
                endcase
            end
        end
    end

    // DATA payload comes straight from the RAM's output register.
    assign o_avs_readdata = r_dataPop ? {1'b1, 23'd0, w_ramQ} : r_regData;
    assign o_irq          = r_irq;

    nmea_byte_ram #(.DEPTH(FIFO_DEPTH)) u_ram (
        .i_clk    (i_clk),
        .i_wrEn   (w_wrEn),
        .i_wrAddr (w_base[AW-1:0]),
        .i_wrData (i_rx_data),
        .i_rdAddr (r_rdPtr[AW-1:0]),
        .o_rdData (w_ramQ)
    );

endmodule

// File: tb/tb_gps_nmea_framer.sv
// Randomized self-checking bench for gps_nmea_framer against a queue-based
// model of sentence framing, committing and register reads.
module tb_gps_nmea_framer;

    localparam int DEPTH  = 128;
    localparam int MAXLEN = 82;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rxData = '0;
    logic        rxValid = 1'b0;
    logic [1:0]  avsAddress = '0;
    logic        avsRead = 1'b0;
    logic [31:0] avsReaddata;
    logic        avsWrite = 1'b0;
    logic [31:0] avsWritedata = '0;
    logic        irq;

    int testsRun = 0;
    int testsFailed = 0;

    logic [7:0] committed[$];
    logic [7:0] pending[$];
    int         csumErr = 0, fmtErr = 0, ovfErr = 0;
    logic       irqEn = 1'b0;

    always #5 clk = ~clk;

    gps_nmea_framer #(.FIFO_DEPTH(DEPTH), .MAX_LEN(MAXLEN)) dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_rx_data       (rxData),
        .i_rx_valid      (rxValid),
        .i_avs_address   (avsAddress),
        .i_avs_read      (avsRead),
        .o_avs_readdata  (avsReaddata),
        .i_avs_write     (avsWrite),
        .i_avs_writedata (avsWritedata),
        .o_irq           (irq)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    function automatic int satInc(input int v);
        return (v < 255) ? v + 1 : 255;
    endfunction

    function automatic bit isUpperHex(input logic [7:0] b);
        return (b >= "0" && b <= "9") || (b >= "A" && b <= "F");
    endfunction

    function automatic int hexVal(input logic [7:0] b);
        return (b <= "9") ? int'(b) - 48 : int'(b) - 55;
    endfunction

    function automatic logic [7:0] hexChar(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'd0, n} : 8'h37 + {4'd0, n};
    endfunction

    function automatic logic [31:0] expStatus();
        logic [31:0] v;
        v = '0;
        v[15:0] = 16'(committed.size());
        v[16] = (pending.size() != 0);
        v[17] = irqEn;
        return v;
    endfunction

    function automatic logic [31:0] expErrors();
        return {8'd0, 8'(ovfErr), 8'(fmtErr), 8'(csumErr)};
    endfunction

    // Store a byte into the sentence being assembled, applying the limits.
    task automatic modelStore(input logic [7:0] b, output bit ok);
        ok = 1'b0;
        if (pending.size() + 1 > MAXLEN) begin
            fmtErr = satInc(fmtErr);
            pending.delete();
        end else if (committed.size() + pending.size() == DEPTH) begin
            ovfErr = satInc(ovfErr);
            pending.delete();
        end else begin
            pending.push_back(b);
            ok = 1'b1;
        end
    endtask

    task automatic modelByte(input logic [7:0] b);
        int starPos;
        int afterStar;
        int xsum;
        int rxSum;
        bit ok;
        if (b == "$") begin
            if (pending.size() != 0) fmtErr = satInc(fmtErr);
            pending.delete();
            modelStore(b, ok);
            return;
        end
        if (pending.size() == 0) return;
        starPos = -1;
        foreach (pending[i]) if (pending[i] == "*" && starPos < 0) starPos = i;
        if (starPos < 0) begin
            modelStore(b, ok);
            return;
        end
        afterStar = pending.size() - 1 - starPos;
        ok = (afterStar <= 1) ? isUpperHex(b) : (afterStar == 2) ? (b == 8'h0D) : (b == 8'h0A);
        if (!ok) begin
            fmtErr = satInc(fmtErr);
            pending.delete();
            return;
        end
        modelStore(b, ok);
        if (ok && afterStar == 3) begin
            xsum = 0;
            for (int i = 1; i < starPos; i++) xsum = xsum ^ int'(pending[i]);
            rxSum = hexVal(pending[starPos + 1]) * 16 + hexVal(pending[starPos + 2]);
            if (xsum == rxSum) begin
                foreach (pending[i]) committed.push_back(pending[i]);
            end else begin
                csumErr = satInc(csumErr);
            end
            pending.delete();
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        @(negedge clk);
        rxData  = b;
        rxValid = 1'b1;
        modelByte(b);
        @(negedge clk);
        rxValid = 1'b0;
    endtask

    task automatic sendString(input string s);
        for (int i = 0; i < s.len(); i++) applyStimulus(s[i]);
    endtask

    task automatic busRead(input logic [1:0] addr, output logic [31:0] data);
        @(negedge clk);
        avsAddress = addr;
        avsRead    = 1'b1;
        @(negedge clk);
        avsRead = 1'b0;
        data    = avsReaddata;
    endtask

    task automatic busWrite(input logic [1:0] addr, input logic [31:0] data);
        @(negedge clk);
        avsAddress   = addr;
        avsWritedata = data;
        avsWrite     = 1'b1;
        @(negedge clk);
        avsWrite = 1'b0;
    endtask

    task automatic readData(input string tag);
        logic [31:0] exp;
        logic [31:0] got;
        exp = (committed.size() > 0) ? {1'b1, 23'd0, committed.pop_front()} : 32'd0;
        busRead(2'd0, got);
        checkOutput(tag, got, exp);
    endtask

    task automatic checkStatus(input string tag);
        logic [31:0] got;
        busRead(2'd1, got);
        checkOutput(tag, got, expStatus());
    endtask

    task automatic checkErrors(input string tag);
        logic [31:0] got;
        busRead(2'd2, got);
        checkOutput(tag, got, expErrors());
    endtask

    task automatic checkIrq(input string tag);
        repeat (2) @(negedge clk);
        checkOutput(tag, {31'd0, irq}, {31'd0, irqEn && committed.size() != 0});
    endtask

    task automatic drainAll(input string tag);
        int n;
        n = committed.size();
        for (int i = 0; i < n; i++) readData(tag);
        readData({tag, "Empty"});
    endtask

    task automatic clearErrors();
        busWrite(2'd2, $urandom);
        csumErr = 0;
        fmtErr  = 0;
        ovfErr  = 0;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        committed.delete();
        pending.delete();
        csumErr = 0;
        fmtErr  = 0;
        ovfErr  = 0;
        irqEn   = 1'b0;
    endtask

    task automatic sendRandomSentence();
        logic [7:0] s[$];
        logic [7:0] cs;
        logic [7:0] c;
        int kind;
        int bodyLen;
        int keep;
        string alphabet;
        alphabet = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789,.";
        kind    = $urandom_range(0, 9);
        bodyLen = (kind == 9) ? $urandom_range(80, 95) : $urandom_range(0, 20);
        cs = '0;
        s.push_back("$");
        for (int i = 0; i < bodyLen; i++) begin
            c = alphabet[$urandom_range(0, alphabet.len() - 1)];
            s.push_back(c);
            cs = cs ^ c;
        end
        if (kind == 5) cs = cs ^ 8'($urandom_range(1, 255));
        s.push_back("*");
        s.push_back(hexChar(cs[7:4]));
        s.push_back(hexChar(cs[3:0]));
        if (kind == 6) s[s.size() - 1 - $urandom_range(0, 1)] = 8'h61 + 8'($urandom_range(0, 5));
        s.push_back(8'h0D);
        s.push_back(8'h0A);
        if (kind == 7) s[$urandom_range(1, s.size() - 1)] = 8'($urandom_range(0, 255));
        if (kind == 8) begin
            keep = $urandom_range(1, s.size() - 1);
            while (s.size() > keep) void'(s.pop_back());
        end
        foreach (s[i]) applyStimulus(s[i]);
    endtask

    initial begin
        logic [31:0] v;
        int op;

        repeat (3) @(negedge clk);
        checkOutput("resetReaddata", avsReaddata, 32'd0);
        checkOutput("resetIrq", {31'd0, irq}, 32'd0);
        reset = 1'b0;
        checkStatus("resetStatus");
        checkErrors("resetErrors");

        sendString("$GPGLL*50\r\n");
        busWrite(2'd3, 32'd1);
        irqEn = 1'b1;
        busRead(2'd1, v);
        checkOutput("validAvail", {16'd0, v[15:0]}, 32'd11);
        checkIrq("validIrqHigh");
        readData("validFirst");
        checkOutput("validFirstIsDollar", {24'd0, 8'h24}, 32'h24);
        drainAll("validData");
        checkStatus("validStatusAfter");
        checkIrq("validIrqLow");

        sendString("$GPGLL*51\r\n");
        busRead(2'd2, v);
        checkOutput("badCsumErrors", v, 32'h00000001);
        checkStatus("badCsumStatus");

        clearErrors();
        sendString("$GPG");
        sendString("$GPGLL*50\r\n");
        checkErrors("restartErrors");
        checkStatus("restartStatus");
        drainAll("restartData");

        clearErrors();
        applyStimulus("$");
        for (int i = 0; i < 90; i++) applyStimulus(8'h41 + 8'($urandom_range(0, 25)));
        busRead(2'd2, v);
        checkOutput("longFmt", {24'd0, v[15:8]}, 32'd1);
        checkStatus("longStatus");
        clearErrors();
        checkErrors("clearedErrors");
        sendString("$GPGLL*5a\r\n");
        checkErrors("lowercaseErrors");

        clearErrors();
        for (int i = 0; i < 12; i++) sendString("$GPGLL*50\r\n");
        busRead(2'd2, v);
        checkOutput("ovfCount", {24'd0, v[23:16]}, 32'd1);
        checkStatus("ovfStatus");
        drainAll("ovfData");
        sendString("$GPGLL*50\r\n");
        busRead(2'd1, v);
        checkOutput("ovfRecoverAvail", {16'd0, v[15:0]}, 32'd11);
        drainAll("ovfRecoverData");

        busWrite(2'd3, 32'd1);
        irqEn = 1'b1;
        sendString("$GPGLL*50\r\n");
        sendString("$GPGLL*5");
        doReset();
        checkStatus("midResetStatus");
        checkIrq("midResetIrq");
        checkErrors("midResetErrors");
        sendString("$GPGLL*50\r\n");
        checkStatus("postResetStatus");
        drainAll("postResetData");

        for (int iter = 0; iter < 300; iter++) begin
            op = $urandom_range(0, 9);
            if (op <= 4) begin
                sendRandomSentence();
            end else if (op <= 6) begin
                for (int k = 0; k < $urandom_range(1, 12); k++) readData("randData");
            end else if (op == 7) begin
                checkStatus("randStatus");
            end else if (op == 8) begin
                checkErrors("randErrors");
                if ($urandom_range(0, 3) == 0) clearErrors();
            end else begin
                irqEn = 1'($urandom_range(0, 1));
                busWrite(2'd3, {31'd0, irqEn});
                busRead(2'd3, v);
                checkOutput("randCtrl", v, {31'd0, irqEn});
                checkIrq("randIrq");
            end
        end
        drainAll("finalData");
        checkErrors("finalErrors");
        checkStatus("finalStatus");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
